// File: rtl/operand_entry_pkg.sv
// Shared types and helpers for the hex operand entry block.
package operand_entry_pkg;

  // Edit FSM encoding, also driven straight onto the state output.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EDIT   = 2'd1,
    ST_HOLD   = 2'd2,
    ST_REPEAT = 2'd3
  } state_t;

  // Button positions within the push vector.
  localparam int unsigned BTN_INC = 0;
  localparam int unsigned BTN_DEC = 1;
  localparam int unsigned BTN_ADV = 2;
  localparam int unsigned NBTN    = 3;

  // Number of hex digits in an operand of the given bit width.
  function automatic int unsigned num_digits(input int unsigned width);
    return width / 4;
  endfunction

  // Cursor register width; kept at least one bit for single-digit operands.
  function automatic int unsigned cursor_width(input int unsigned nd);
    int unsigned w;
    w = (nd < 2) ? 1 : $clog2(nd);
    return w;
  endfunction

endpackage

// File: rtl/edge_repeat.sv
// Button edge detection plus the hold / auto-repeat edit FSM.
// Emits one-cycle step pulses (with direction) and cursor-advance pulses.
module edge_repeat
  import operand_entry_pkg::*;
#(
  parameter int unsigned REPEAT_DLY = 25_000_000,
  parameter int unsigned REPEAT_PER = 5_000_000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NBTN-1:0] push_i,
  input  logic            en_i,
  input  logic            restart_i,
  input  logic            freeze_i,
  output state_t          state_o,
  output logic            step_o,
  output logic            step_dn_o,
  output logic            adv_o
);

  localparam logic [31:0] DLY_LAST = 32'(REPEAT_DLY - 1);
  localparam logic [31:0] PER_LAST = 32'(REPEAT_PER - 1);

  logic [NBTN-1:0] push_q;
  logic [NBTN-1:0] armed_q;
  logic [NBTN-1:0] ev;
  state_t          state_q;
  logic            dir_q;
  logic            step_q;
  logic            adv_q;
  logic [31:0]     cnt_q;
  logic            both;
  logic            held;

  // Press events; a button must be seen released once after reset before it
  // can produce an event, so a button held through reset is not a press.
  always_comb begin
    ev   = push_i & ~push_q & armed_q;
    both = push_i[BTN_INC] & push_i[BTN_DEC];
    held = dir_q ? push_i[BTN_DEC] : push_i[BTN_INC];
  end

  // Button sampling and re-arm tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push_q  <= '0;
      armed_q <= '0;
    end else begin
      push_q  <= push_i;
      armed_q <= armed_q | ~push_i;
    end
  end

  // Edit FSM with hold/repeat timing; step and advance pulses are registered
  // and consumed by the operand datapath one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
      adv_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      step_q <= 1'b0;
      adv_q  <= 1'b0;
      if (!en_i) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end else if (freeze_i) begin
        state_q <= state_q;
      end else if (restart_i) begin
        state_q <= ST_EDIT;
        cnt_q   <= '0;
      end else begin
        if (state_q != ST_IDLE) begin
          adv_q <= ev[BTN_ADV];
        end
        unique case (state_q)
          ST_IDLE: begin
            state_q <= ST_EDIT;
          end
          ST_EDIT: begin
            if (!both && (ev[BTN_INC] || ev[BTN_DEC])) begin
              state_q <= ST_HOLD;
              step_q  <= 1'b1;
              dir_q   <= ~ev[BTN_INC];
              cnt_q   <= '0;
            end
          end
          ST_HOLD: begin
            if (both || !held) begin
              state_q <= ST_EDIT;
            end else if (cnt_q == DLY_LAST) begin
              state_q <= ST_REPEAT;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 32'd1;
            end
          end
          ST_REPEAT: begin
            if (both || !held) begin
              state_q <= ST_EDIT;
            end else if (cnt_q == PER_LAST) begin
              step_q <= 1'b1;
              cnt_q  <= '0;
            end else begin
              cnt_q <= cnt_q + 32'd1;
            end
          end
        endcase
      end
    end
  end

  // A pulse already in flight is dropped if editing is disabled, the operand
  // selection changes, or the selection is invalid in the cycle it would act.
  always_comb begin
    state_o   = state_q;
    step_o    = step_q & en_i & ~restart_i & ~freeze_i;
    step_dn_o = dir_q;
    adv_o     = adv_q & en_i & ~restart_i & ~freeze_i;
  end

endmodule

// File: rtl/operand_entry.sv
// Push-button hex operand entry: per-digit inc/dec with auto-repeat,
// cursor advance, operand select and cursor blink mask.
module operand_entry
  import operand_entry_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned NOPS       = 2,
  parameter int unsigned REPEAT_DLY = 25_000_000,
  parameter int unsigned REPEAT_PER = 5_000_000,
  parameter int unsigned BLINK_DIV  = 12_500_000
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [2:0]                                  push,
  input  logic                                        edit_en,
  input  logic [1:0]                                  op_sel,
  output logic [NOPS*WIDTH-1:0]                       ops,
  output logic [cursor_width(num_digits(WIDTH))-1:0]  cursor,
  output logic [1:0]                                  state,
  output logic [num_digits(WIDTH)-1:0]                blink
);

  localparam int unsigned   ND         = num_digits(WIDTH);
  localparam int unsigned   CW         = cursor_width(ND);
  localparam logic [CW-1:0] CUR_LAST   = CW'(ND - 1);
  localparam logic [31:0]   BLINK_LAST = 32'(BLINK_DIV - 1);

  logic [NOPS*WIDTH-1:0] ops_q;
  logic [NOPS*WIDTH-1:0] ops_d;
  logic [CW-1:0]         cursor_q;
  logic [CW-1:0]         cursor_d;
  logic [1:0]            opsel_q;
  logic [31:0]           blink_cnt_q;
  logic                  blink_ph_q;
  logic                  sel_valid;
  logic                  restart;
  logic                  step;
  logic                  step_dn;
  logic                  adv;
  state_t                st;

  // Operand selection: only valid values are remembered, so leaving and
  // returning to the same operand through an invalid value is not a change.
  always_comb begin
    sel_valid = (32'(op_sel) < NOPS);
    restart   = sel_valid && (op_sel != opsel_q);
  end

  edge_repeat #(
    .REPEAT_DLY (REPEAT_DLY),
    .REPEAT_PER (REPEAT_PER)
  ) u_edge_repeat (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (push),
    .en_i      (edit_en),
    .restart_i (restart),
    .freeze_i  (~sel_valid),
    .state_o   (st),
    .step_o    (step),
    .step_dn_o (step_dn),
    .adv_o     (adv)
  );

  // Next operand and cursor; a step uses the cursor before any same-cycle
  // advance, and digits wrap modulo 16 without touching neighbours.
  always_comb begin
    ops_d = ops_q;
    if (step) begin
      for (int unsigned k = 0; k < NOPS; k++) begin
        for (int unsigned d = 0; d < ND; d++) begin
          if (k == 32'(opsel_q) && d == 32'(cursor_q)) begin
            ops_d[k*WIDTH + d*4 +: 4] = step_dn ? ops_q[k*WIDTH + d*4 +: 4] - 4'd1
                                                : ops_q[k*WIDTH + d*4 +: 4] + 4'd1;
          end
        end
      end
    end
    cursor_d = cursor_q;
    if (restart) begin
      cursor_d = '0;
    end else if (adv) begin
      cursor_d = (cursor_q == CUR_LAST) ? '0 : cursor_q + 1'b1;
    end
  end

  // Operand, cursor and selection registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_q    <= '0;
      cursor_q <= '0;
      opsel_q  <= '0;
    end else begin
      ops_q    <= ops_d;
      cursor_q <= cursor_d;
      if (sel_valid) begin
        opsel_q <= op_sel;
      end
    end
  end

  // Free-running blink phase generator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_q <= '0;
      blink_ph_q  <= ~blink_ph_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 32'd1;
    end
  end

  // Blank mask: the digit under the cursor during the active blink phase.
  always_comb begin
    blink = '0;
    if (blink_ph_q && st != ST_IDLE) begin
      blink[cursor_q] = 1'b1;
    end
  end

  assign ops    = ops_q;
  assign cursor = cursor_q;
  assign state  = st;

endmodule

// File: tb/tb_operand_entry.sv
// Scoreboard bench for operand_entry (WIDTH=32, NOPS=2, short timing params).
module tb_operand_entry;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EDIT   = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;
  localparam logic [1:0] S_REPEAT = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  push;
  logic        edit_en;
  logic [1:0]  op_sel;
  logic [63:0] ops;
  logic [2:0]  cursor;
  logic [1:0]  state;
  logic [7:0]  blink;

  typedef struct packed {
    logic [63:0] ops;
    logic [2:0]  cur;
    logic [1:0]  st;
  } obs_t;

  obs_t        sb[$];
  logic [7:0]  bsb[$];
  obs_t        e;
  obs_t        g;
  logic [7:0]  eb;
  logic [63:0] m_ops;
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  operand_entry #(
    .WIDTH      (32),
    .NOPS       (2),
    .REPEAT_DLY (8),
    .REPEAT_PER (4),
    .BLINK_DIV  (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .edit_en (edit_en),
    .op_sel  (op_sel),
    .ops     (ops),
    .cursor  (cursor),
    .state   (state),
    .blink   (blink)
  );

  // Reference digit update: modulo-16 on one nibble only.
  function automatic logic [63:0] bump(input logic [63:0] v, input int op, input int dig, input bit dn);
    logic [3:0] n;
    n = v[op*32 + dig*4 +: 4];
    n = dn ? n - 4'd1 : n + 4'd1;
    v[op*32 + dig*4 +: 4] = n;
    return v;
  endfunction

  // Called just after a falling edge; returns two falling edges later,
  // by which time the resulting step/advance is visible.
  task automatic press(input int b);
    push[b] = 1'b1;
    @(negedge clk);
    push[b] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    push = '0; edit_en = 1'b0; op_sel = 2'd0; rst_n = 1'b0; m_ops = '0;
    repeat (2) @(negedge clk);
    sb.push_back({64'h0, 3'd0, S_IDLE});
    g = {ops, cursor, state}; e = sb.pop_front(); n_cmp++;
    if (g !== e) begin n_fail++; $display("FAIL reset: got ops=%h cur=%0d st=%0d, want ops=%h cur=%0d st=%0d", g.ops, g.cur, g.st, e.ops, e.cur, e.st); end
    n_cmp++;
    if (blink !== 8'h00) begin n_fail++; $display("FAIL reset_blink: got %h want 00", blink); end
    rst_n = 1'b1; edit_en = 1'b1;
    repeat (2) @(negedge clk);
    sb.push_back({m_ops, 3'd0, S_EDIT});
    g = {ops, cursor, state}; e = sb.pop_front(); n_cmp++;
    if (g !== e) begin n_fail++; $display("FAIL enter_edit: got ops=%h cur=%0d st=%0d, want ops=%h cur=%0d st=%0d", g.ops, g.cur, g.st, e.ops, e.cur, e.st); end
  endtask

  task automatic test_inc();
    for (int i = 0; i < 3; i++) begin
      m_ops = bump(m_ops, 0, 0, 1'b0);
      sb.push_back({m_ops, 3'd0, S_EDIT});
      press(0);
      g = {ops, cursor, state}; e = sb.pop_front(); n_cmp++;
      if (g !== e) begin n_fail++; $display("FAIL inc%0d: got ops=%h cur=%0d st=%0d, want ops=%h cur=%0d st=%0d", i, g.ops, g.cur, g.st, e.ops, e.cur, e.st); end
    end
    n_cmp++;
    if (ops !== 64'h0000_0000_0000_0003) begin n_fail++; $display("FAIL inc_total: got %h want 0000000000000003", ops); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 5; i++) begin
      m_ops = bump(m_ops, 0, 0, (i < 4));
      sb.push_back({m_ops, 3'd0, S_EDIT});
      press((i < 4) ? 1 : 0);
      g = {ops, cursor, state}; e = sb.pop_front(); n_cmp++;
      if (g !== e) begin n_fail++; $display("FAIL wrap%0d: got ops=%h cur=%0d st=%0d, want ops=%h cur=%0d st=%0d", i, g.ops, g.cur, g.st, e.ops, e.cur, e.st); end
      if (i == 3) begin
        n_cmp++;
        if (ops[31:0] !== 32'h0000_000F) begin n_fail++; $display("FAIL wrap_borrow: got %h want 0000000f", ops[31:0]); end
      end
    end
  endtask

  task automatic test_hold();
    logic [1:0] st;
    for (int j = 1; j <= 22; j++) begin
      if (j == 2 || j == 14 || j == 18 || j == 22) m_ops = bump(m_ops, 0, 0, 1'b0);
      st = (j <= 8) ? S_HOLD : ((j <= 21) ? S_REPEAT : S_EDIT);
      sb.push_back({m_ops, 3'd0, st});
    end
    push[0] = 1'b1;
    for (int j = 1; j <= 22; j++) begin
      @(negedge clk);
      g = {ops, cursor, state}; e = sb.pop_front(); n_cmp++;
      if (g !== e) begin n_fail++; $display("FAIL hold%0d: got ops=%h cur=%0d st=%0d, want ops=%h cur=%0d st=%0d", j, g.ops, g.cur, g.st, e.ops, e.cur, e.st); end
      if (j == 21) push[0] = 1'b0;
    end
    n_cmp++;
    if (ops[3:0] !== 4'h4) begin n_fail++; $display("FAIL hold_total: got %h want 4", ops[3:0]); end
  endtask

  task automatic test_both();
    push = 3'b011;
    for (int j = 0; j < 3; j++) begin
      sb.push_back({m_ops, 3'd0, S_EDIT});
      @(negedge clk);
      g = {ops, cursor, state}; e = sb.pop_front(); n_cmp++;
      if (g !== e) begin n_fail++; $display("FAIL both%0d: got ops=%h cur=%0d st=%0d, want ops=%h cur=%0d st=%0d", j, g.ops, g.cur, g.st, e.ops, e.cur, e.st); end
    end
    push = '0;
    @(negedge clk);
  endtask

  task automatic test_cursor();
    for (int i = 1; i <= 8; i++) begin
      sb.push_back({m_ops, 3'(i % 8), S_EDIT});
      press(2);
      g = {ops, cursor, state}; e = sb.pop_front(); n_cmp++;
      if (g !== e) begin n_fail++; $display("FAIL adv%0d: got ops=%h cur=%0d st=%0d, want ops=%h cur=%0d st=%0d", i, g.ops, g.cur, g.st, e.ops, e.cur, e.st); end
    end
    // Step and advance together: step lands on the old cursor.
    m_ops = bump(m_ops, 0, 0, 1'b0);
    sb.push_back({m_ops, 3'd1, S_EDIT});
    push = 3'b101;
    @(negedge clk);
    push = '0;
    @(negedge clk);
    g = {ops, cursor, state}; e = sb.pop_front(); n_cmp++;
    if (g !== e) begin n_fail++; $display("FAIL step_adv: got ops=%h cur=%0d st=%0d, want ops=%h cur=%0d st=%0d", g.ops, g.cur, g.st, e.ops, e.cur, e.st); end
    press(2);
    press(2);
  endtask

  task automatic test_blink();
    int t;
    t = 0;
    while (blink !== 8'h00 && t < 20) begin @(negedge clk); t++; end
    while (blink === 8'h00 && t < 40) begin @(negedge clk); t++; end
    n_cmp++;
    if (blink === 8'h00) begin n_fail++; $display("FAIL blink_start: got 00 want 08 within 40 cycles"); end
    for (int i = 0; i < 12; i++) begin
      bsb.push_back((i < 4 || i >= 8) ? 8'h08 : 8'h00);
      eb = bsb.pop_front(); n_cmp++;
      if (blink !== eb) begin n_fail++; $display("FAIL blink%0d: got %h want %h", i, blink, eb); end
      @(negedge clk);
    end
    edit_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({blink, state} !== {8'h00, S_IDLE}) begin n_fail++; $display("FAIL idle%0d: got blink=%h st=%0d want blink=00 st=0", i, blink, state); end
    end
    edit_en = 1'b1;
    sb.push_back({m_ops, 3'd3, S_EDIT});
    @(negedge clk);
    g = {ops, cursor, state}; e = sb.pop_front(); n_cmp++;
    if (g !== e) begin n_fail++; $display("FAIL reenable: got ops=%h cur=%0d st=%0d, want ops=%h cur=%0d st=%0d", g.ops, g.cur, g.st, e.ops, e.cur, e.st); end
  endtask

  task automatic test_opsel();
    press(2);
    press(2);
    sb.push_back({m_ops, 3'd5, S_EDIT});
    g = {ops, cursor, state}; e = sb.pop_front(); n_cmp++;
    if (g !== e) begin n_fail++; $display("FAIL cur5: got ops=%h cur=%0d st=%0d, want ops=%h cur=%0d st=%0d", g.ops, g.cur, g.st, e.ops, e.cur, e.st); end
    op_sel = 2'd1;
    sb.push_back({m_ops, 3'd0, S_EDIT});
    @(negedge clk);
    g = {ops, cursor, state}; e = sb.pop_front(); n_cmp++;
    if (g !== e) begin n_fail++; $display("FAIL sel1: got ops=%h cur=%0d st=%0d, want ops=%h cur=%0d st=%0d", g.ops, g.cur, g.st, e.ops, e.cur, e.st); end
    m_ops = bump(m_ops, 1, 0, 1'b0);
    sb.push_back({m_ops, 3'd0, S_EDIT});
    press(0);
    g = {ops, cursor, state}; e = sb.pop_front(); n_cmp++;
    if (g !== e) begin n_fail++; $display("FAIL sel1_inc: got ops=%h cur=%0d st=%0d, want ops=%h cur=%0d st=%0d", g.ops, g.cur, g.st, e.ops, e.cur, e.st); end
    n_cmp++;
    if (ops[63:32] !== 32'h0000_0001) begin n_fail++; $display("FAIL sel1_word: got %h want 00000001", ops[63:32]); end
    press(2);
    press(2);
    op_sel = 2'd3;
    sb.push_back({m_ops, 3'd2, S_EDIT});
    @(negedge clk);
    press(0);
    press(1);
    press(2);
    g = {ops, cursor, state}; e = sb.pop_front(); n_cmp++;
    if (g !== e) begin n_fail++; $display("FAIL sel3_frozen: got ops=%h cur=%0d st=%0d, want ops=%h cur=%0d st=%0d", g.ops, g.cur, g.st, e.ops, e.cur, e.st); end
    op_sel = 2'd0;
    sb.push_back({m_ops, 3'd0, S_EDIT});
    @(negedge clk);
    g = {ops, cursor, state}; e = sb.pop_front(); n_cmp++;
    if (g !== e) begin n_fail++; $display("FAIL sel0: got ops=%h cur=%0d st=%0d, want ops=%h cur=%0d st=%0d", g.ops, g.cur, g.st, e.ops, e.cur, e.st); end
  endtask

  task automatic test_reset_repeat();
    int t;
    push[0] = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (state !== S_REPEAT && t < 30);
    n_cmp++;
    if (t !== 9) begin n_fail++; $display("FAIL repeat_entry: got %0d cycles want 9", t); end
    m_ops = bump(m_ops, 0, 0, 1'b0);
    sb.push_back({m_ops, 3'd0, S_REPEAT});
    g = {ops, cursor, state}; e = sb.pop_front(); n_cmp++;
    if (g !== e) begin n_fail++; $display("FAIL pre_reset: got ops=%h cur=%0d st=%0d, want ops=%h cur=%0d st=%0d", g.ops, g.cur, g.st, e.ops, e.cur, e.st); end
    #2 rst_n = 1'b0;
    #1;
    m_ops = '0;
    sb.push_back({m_ops, 3'd0, S_IDLE});
    g = {ops, cursor, state}; e = sb.pop_front(); n_cmp++;
    if (g !== e || blink !== 8'h00) begin n_fail++; $display("FAIL async_reset: got ops=%h cur=%0d st=%0d blink=%h, want ops=%h cur=%0d st=%0d blink=00", g.ops, g.cur, g.st, blink, e.ops, e.cur, e.st); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sb.push_back({m_ops, 3'd0, S_EDIT});
      @(negedge clk);
      g = {ops, cursor, state}; e = sb.pop_front(); n_cmp++;
      if (g !== e) begin n_fail++; $display("FAIL held_after_reset%0d: got ops=%h cur=%0d st=%0d, want ops=%h cur=%0d st=%0d", i, g.ops, g.cur, g.st, e.ops, e.cur, e.st); end
    end
    push[0] = 1'b0;
    @(negedge clk);
    m_ops = bump(m_ops, 0, 0, 1'b0);
    sb.push_back({m_ops, 3'd0, S_EDIT});
    press(0);
    g = {ops, cursor, state}; e = sb.pop_front(); n_cmp++;
    if (g !== e) begin n_fail++; $display("FAIL repress: got ops=%h cur=%0d st=%0d, want ops=%h cur=%0d st=%0d", g.ops, g.cur, g.st, e.ops, e.cur, e.st); end
  endtask

  initial begin
    test_reset();
    test_inc();
    test_wrap();
    test_hold();
    test_both();
    test_cursor();
    test_blink();
    test_opsel();
    test_reset_repeat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/operand_entry.md
OPERAND_ENTRY -- requirements
Module: operand_entry

Interface
REQ-001 SHALL provide parameter WIDTH, default 32: operand width in bits, multiple of 4; ND = WIDTH/4 hex digits.
REQ-002 SHALL provide parameter NOPS, default 2: operand count, range 2..4.
REQ-003 SHALL provide parameter REPEAT_DLY, default 25_000_000: cycles a held inc/dec button must stay held before auto-repeat starts.
REQ-004 SHALL provide parameter REPEAT_PER, default 5_000_000: cycles between auto-repeat steps.
REQ-005 SHALL provide parameter BLINK_DIV, default 12_500_000: cycles per blink phase.
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 push  in  3  debounced button levels: [0] increment digit, [1] decrement digit, [2] advance cursor.
REQ-009 edit_en  in  1  1 = editing enabled.
REQ-010 op_sel  in  2  operand being edited; values >= NOPS are ignored.
REQ-011 ops  out  NOPS*WIDTH  operand k on bits [k*WIDTH +: WIDTH].
REQ-012 cursor  out  clog2(ND)  digit index under edit, 0 = least significant.
REQ-013 state  out  2  FSM state encoding.
REQ-014 blink  out  ND  per-digit blank mask for the display.

Function
REQ-015 Inputs push sampled into a register; press event = rising edge (push & ~push_q); events act in the cycle after the edge is sampled.
REQ-016 FSM states: IDLE=0, EDIT=1, HOLD=2, REPEAT=3.
REQ-017 IDLE->EDIT when edit_en=1; any state->IDLE when edit_en=0, same cycle, no digit change.
REQ-018 EDIT: inc/dec event changes addressed digit by +/-1 modulo 16, no carry/borrow to neighbours (F+1=0, 0-1=F); then ->HOLD.
REQ-019 HOLD: counts cycles while the same inc/dec button stays held; at REPEAT_DLY ->REPEAT; release ->EDIT.
REQ-020 REPEAT: applies one further step every REPEAT_PER cycles, first step REPEAT_PER cycles after entry; release ->EDIT.
REQ-021 push[0] and push[1] both high: no digit change, FSM returns to/stays in EDIT.
REQ-022 push[2] event: cursor+1, wraps ND-1 -> 0; allowed in any non-IDLE state; if same cycle as an inc/dec step, step applies at old cursor, cursor then advances.
REQ-023 op_sel change (valid value): cursor forced to 0 next cycle, FSM ->EDIT, pending step discarded.
REQ-024 op_sel >= NOPS: no operand modified; cursor and FSM hold.
REQ-025 Blink: free-running counter toggles phase every BLINK_DIV cycles; blink = one-hot(cursor) when phase=1 and state!=IDLE, else all zero.
REQ-026 Operand values persist through IDLE and op_sel changes; only an edit step or reset alters them.

Reset
REQ-027 rst_n low SHALL immediately clear: ops=0, cursor=0, state=IDLE, blink=0, push_q=0, repeat and blink counters=0.
REQ-028 Reset mid-HOLD/REPEAT SHALL abort without applying a further step; after release, a still-held button SHALL NOT count as a press until released and re-pressed.

Structure
REQ-029 Package operand_entry_pkg SHALL hold state encoding constants and the digit-count/cursor-width helper.
REQ-030 One sub-module edge_repeat SHALL implement per-button edge detection plus HOLD/REPEAT timing, emitting a one-cycle step pulse.

Verification (WIDTH=32, NOPS=2, REPEAT_DLY=8, REPEAT_PER=4, BLINK_DIV=4)
REQ-031 Reset, edit_en=1, op_sel=0, press push[0] 3 times -> ops[31:0]=0x00000003, ops[63:32]=0.
REQ-032 Digit at F, push[0] press -> digit 0, adjacent digit unchanged; digit 0, push[1] press -> F.
REQ-033 Hold push[0] 20 cycles from edge -> 1 step + repeats at cycles 12,16,20 = digit value 4; state sequence EDIT,HOLD,REPEAT.
REQ-034 Press push[2] 8 times -> cursor 1..7 then 0; blink toggles one-hot(cursor) every 4 cycles, zero when edit_en=0.
REQ-035 op_sel=1 with cursor=5 -> cursor 0, push[0] modifies ops[35:32] only; op_sel=3 -> no change anywhere.
REQ-036 rst_n low during REPEAT with push[0] held -> all outputs 0 asynchronously; after release no step until push[0] released and re-pressed.
